// File: rtl/lsu_misalign_seq.sv
// Load/store sequencer between the MEM stage and data_mem: aligned accesses pass straight through,
// misaligned half/word accesses stall the core and are replayed as single-byte accesses.
module lsu_misalign_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_ctrl,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  stall,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_a,
   output logic                  mem_we,
   output logic [2:0]            mem_ctrl,
   output logic [DATA_WIDTH-1:0] mem_wd,
   input  logic [DATA_WIDTH-1:0] mem_rd
);

   typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic [2:0]            ctrl_q, ctrl_d;
   logic                  we_q, we_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;

   logic                  misaligned;
   logic                  last_idx;
   logic                  ext;
   logic [7:0]            st_byte;

   always_comb begin
      misaligned = req_valid && ((req_ctrl[1:0] == 2'b01 && req_addr[0]) ||
                                 (req_ctrl[1:0] == 2'b10 && req_addr[1:0] != 2'b00));
      last_idx   = (idx_q == (ctrl_q[1] ? 2'd3 : 2'd1));
      ext        = ~ctrl_q[2] & buf_q[15];
      st_byte    = wdata_q[{idx_q, 3'b000} +: 8];

      state_d = state_q;
      idx_d   = idx_q;
      base_d  = base_q;
      ctrl_d  = ctrl_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      buf_d   = buf_q;

      stall     = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = '0;
      mem_a     = req_addr;
      mem_we    = 1'b0;
      mem_ctrl  = req_ctrl;
      mem_wd    = req_wdata;

      unique case (state_q)
         IDLE: begin
            if (misaligned) begin
               stall   = 1'b1;
               state_d = SPLIT;
               base_d  = req_addr;
               ctrl_d  = req_ctrl;
               we_d    = req_we;
               wdata_d = req_wdata;
               idx_d   = 2'd0;
               buf_d   = '0;
            end else begin
               mem_we    = req_valid && req_we;
               rsp_valid = req_valid;
               rsp_rdata = req_valid ? mem_rd : '0;
            end
         end
         SPLIT: begin
            // One byte per cycle; the address wraps naturally at the top of the space.
            stall    = 1'b1;
            mem_a    = base_q + ADDR_WIDTH'(idx_q);
            mem_ctrl = 3'b100;
            mem_we   = we_q;
            mem_wd   = we_q ? {{(DATA_WIDTH-8){1'b0}}, st_byte} : '0;
            if (!we_q)
               buf_d[{idx_q, 3'b000} +: 8] = mem_rd[7:0];
            idx_d = idx_q + 2'd1;
            if (last_idx)
               state_d = DONE;
         end
         DONE: begin
            // Inputs still show the finished access here, so never start a new one.
            rsp_valid = 1'b1;
            mem_a     = base_q;
            mem_ctrl  = ctrl_q;
            mem_wd    = '0;
            rsp_rdata = ctrl_q[1] ? buf_q : {{(DATA_WIDTH-16){ext}}, buf_q[15:0]};
            idx_d     = 2'd0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (rst) begin
         stall     = 1'b0;
         rsp_valid = 1'b0;
         mem_we    = 1'b0;
         rsp_rdata = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= 2'd0;
         base_q  <= '0;
         ctrl_q  <= 3'b000;
         we_q    <= 1'b0;
         wdata_q <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         base_q  <= base_d;
         ctrl_q  <= ctrl_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
      end
   end

endmodule

// File: tb/tb_lsu_misalign_seq.sv
// Directed bench for lsu_misalign_seq with a byte-addressed data_mem model (1 KiB, address bits [9:0]).
module tb_lsu_misalign_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [2:0]  req_ctrl = 3'b000;
   logic [31:0] req_wdata = 32'h0;
   logic        stall, rsp_valid, mem_we;
   logic [31:0] rsp_rdata, mem_a, mem_wd, mem_rd;
   logic [2:0]  mem_ctrl;

   int n_checks = 0;
   int n_pass = 0;

   logic [7:0] mem_arr [0:1023];
   logic       fill_en = 1'b0;
   int         fill_lo = 0;
   int         fill_hi = 0;
   logic [7:0] fill_val = 8'h00;
   logic [9:0] ra, wa;
   logic [7:0] rb0, rb1, rb2, rb3;

   lsu_misalign_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_ctrl(req_ctrl), .req_wdata(req_wdata),
      .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_a(mem_a), .mem_we(mem_we), .mem_ctrl(mem_ctrl), .mem_wd(mem_wd),
      .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   // data_mem model: combinational little-endian read, byte/half/word write
   always_comb begin
      ra  = mem_a[9:0];
      rb0 = mem_arr[ra];
      rb1 = mem_arr[ra + 10'd1];
      rb2 = mem_arr[ra + 10'd2];
      rb3 = mem_arr[ra + 10'd3];
      case (mem_ctrl[1:0])
         2'b00:   mem_rd = {{24{rb0[7] & ~mem_ctrl[2]}}, rb0};
         2'b01:   mem_rd = {{16{rb1[7] & ~mem_ctrl[2]}}, rb1, rb0};
         default: mem_rd = {rb3, rb2, rb1, rb0};
      endcase
   end

   always @(posedge clk) begin
      wa = mem_a[9:0];
      if (fill_en) begin
         for (int i = 0; i < 1024; i++)
            if (i >= fill_lo && i <= fill_hi) mem_arr[i] <= fill_val;
      end else if (mem_we) begin
         mem_arr[wa] <= mem_wd[7:0];
         if (mem_ctrl[1:0] != 2'b00) mem_arr[wa + 10'd1] <= mem_wd[15:8];
         if (mem_ctrl[1]) begin
            mem_arr[wa + 10'd2] <= mem_wd[23:16];
            mem_arr[wa + 10'd3] <= mem_wd[31:24];
         end
      end
   end

   task automatic fill(input int lo, input int hi, input logic [7:0] val);
      fill_lo = lo; fill_hi = hi; fill_val = val; fill_en = 1'b1;
      @(negedge clk);
      fill_en = 1'b0;
   endtask

   task automatic init_mem();
      logic [63:0] words;
      words = 64'hDEADBEEF_12345678;
      fill(0, 1023, 8'h00);
      for (int i = 0; i < 8; i++) fill(i, i, words[8*i +: 8]);
   endtask

   task automatic set_req(input logic v, input logic we, input logic [31:0] a,
                          input logic [2:0] c, input logic [31:0] wd);
      req_valid = v; req_we = we; req_addr = a; req_ctrl = c; req_wdata = wd;
   endtask

   task automatic test_reset();
      @(negedge clk);
      set_req(1'b1, 1'b1, 32'h4, 3'b010, 32'hCAFEF00D);
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we} !== 3'b000) $display("FAIL reset_ctrl got=%b exp=000", {stall, rsp_valid, mem_we});
      else n_pass++;
      n_checks++;
      if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata got=%h exp=00000000", rsp_rdata);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      set_req(1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we} !== 3'b000) $display("FAIL post_reset_idle got=%b exp=000", {stall, rsp_valid, mem_we});
      else n_pass++;
      $display("reset: outputs quiet during and after reset");
   endtask

   task automatic test_aligned();
      set_req(1'b1, 1'b0, 32'h4, 3'b010, 32'h0);
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b01, 32'hDEADBEEF}) $display("FAIL aligned_lw got=%b/%h exp=01/deadbeef", {stall, rsp_valid}, rsp_rdata);
      else n_pass++;
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'h7, 3'b100, 32'h0);
      #1;
      n_checks++;
      if (rsp_rdata !== 32'h000000DE || rsp_valid !== 1'b1) $display("FAIL aligned_lbu got=%h exp=000000de", rsp_rdata);
      else n_pass++;
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'h7, 3'b000, 32'h0);
      #1;
      n_checks++;
      if (rsp_rdata !== 32'hFFFFFFDE || stall !== 1'b0) $display("FAIL aligned_lb got=%h exp=ffffffde", rsp_rdata);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      $display("aligned: lw @4, lbu @7, lb @7 done");
   endtask

   task automatic test_misaligned_word();
      set_req(1'b1, 1'b0, 32'h2, 3'b010, 32'h0);
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we} !== 3'b100) $display("FAIL lw2_first got=%b exp=100", {stall, rsp_valid, mem_we});
      else n_pass++;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (stall !== 1'b1 || rsp_valid !== 1'b0 || mem_a !== 32'h2 + 32'(i) || mem_ctrl !== 3'b100)
            $display("FAIL lw2_split%0d got a=%h stall=%b ctrl=%b exp a=%h stall=1 ctrl=100", i, mem_a, stall, mem_ctrl, 32'h2 + 32'(i));
         else n_pass++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b01, 32'hBEEF1234}) $display("FAIL lw2_done got=%b/%h exp=01/beef1234", {stall, rsp_valid}, rsp_rdata);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      $display("misaligned lw @2 -> %h", 32'hBEEF1234);
   endtask

   task automatic test_misaligned_half(input logic zext, input logic [31:0] exp);
      set_req(1'b1, 1'b0, 32'h3, {zext, 2'b01}, 32'h0);
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we} !== 3'b100) $display("FAIL lh3_first got=%b exp=100", {stall, rsp_valid, mem_we});
      else n_pass++;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if (stall !== 1'b1 || mem_a !== 32'h3 + 32'(i)) $display("FAIL lh3_split%0d got a=%h stall=%b exp a=%h stall=1", i, mem_a, stall, 32'h3 + 32'(i));
         else n_pass++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b01, exp}) $display("FAIL lh3_done zext=%b got=%b/%h exp=01/%h", zext, {stall, rsp_valid}, rsp_rdata, exp);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b00, 32'h0}) $display("FAIL lh3_idle got=%b/%h exp=00/00000000", {stall, rsp_valid}, rsp_rdata);
      else n_pass++;
      $display("misaligned lh%s @3 -> %h", zext ? "u" : "", exp);
   endtask

   task automatic test_store();
      logic [31:0] exp_wd;
      fill(32'h100, 32'h1FF, 8'hAA);
      set_req(1'b1, 1'b1, 32'h101, 3'b010, 32'hA1B2C3D4);
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we} !== 3'b100) $display("FAIL sw101_first got=%b exp=100", {stall, rsp_valid, mem_we});
      else n_pass++;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         exp_wd = (32'hA1B2C3D4 >> (8 * i)) & 32'hFF;
         #1;
         n_checks++;
         if ({stall, mem_we} !== 2'b11 || mem_a !== 32'h101 + 32'(i) || mem_wd !== exp_wd)
            $display("FAIL sw101_byte%0d got a=%h wd=%h we=%b exp a=%h wd=%h we=1", i, mem_a, mem_wd, mem_we, 32'h101 + 32'(i), exp_wd);
         else n_pass++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we} !== 3'b010) $display("FAIL sw101_done got=%b exp=010", {stall, rsp_valid, mem_we});
      else n_pass++;
      @(negedge clk);
      set_req(1'b1, 1'b0, 32'h100, 3'b010, 32'h0);
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b01, 32'hB2C3D4AA}) $display("FAIL sw101_readback got=%b/%h exp=01/b2c3d4aa", {stall, rsp_valid}, rsp_rdata);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      $display("misaligned sw a1b2c3d4 @101; lw @100 -> %h", 32'hB2C3D4AA);
   endtask

   task automatic test_reset_mid_split();
      fill(32'h200, 32'h204, 8'h55);
      set_req(1'b1, 1'b1, 32'h201, 3'b010, 32'h11223344);
      #1;
      @(negedge clk);
      #1;
      n_checks++;
      if ({stall, mem_we} !== 2'b11 || mem_a !== 32'h201 || mem_wd !== 32'h44) $display("FAIL rstsplit_byte0 got a=%h wd=%h we=%b exp a=00000201 wd=00000044 we=1", mem_a, mem_wd, mem_we);
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if (mem_a !== 32'h202 || mem_we !== 1'b1) $display("FAIL rstsplit_byte1 got a=%h we=%b exp a=00000202 we=1", mem_a, mem_we);
      else n_pass++;
      rst = 1'b1;
      req_valid = 1'b0;
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we} !== 3'b000) $display("FAIL rstsplit_abort got=%b exp=000", {stall, rsp_valid, mem_we});
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if ({mem_arr[10'h201], mem_arr[10'h202], mem_arr[10'h203], mem_arr[10'h204]} !== 32'h44555555)
         $display("FAIL rstsplit_mem got=%h exp=44555555", {mem_arr[10'h201], mem_arr[10'h202], mem_arr[10'h203], mem_arr[10'h204]});
      else n_pass++;
      set_req(1'b1, 1'b0, 32'h200, 3'b010, 32'h0);
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b01, 32'h55554455}) $display("FAIL rstsplit_next got=%b/%h exp=01/55554455", {stall, rsp_valid}, rsp_rdata);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      $display("reset during sw 11223344 @201: only 0x201 written");
   endtask

   task automatic test_wrap();
      fill(32'h3FE, 32'h3FE, 8'h11);
      fill(32'h3FF, 32'h3FF, 8'h22);
      set_req(1'b1, 1'b0, 32'hFFFFFFFE, 3'b010, 32'h0);
      #1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (mem_a !== 32'hFFFFFFFE + 32'(i) || stall !== 1'b1) $display("FAIL wrap_split%0d got a=%h exp a=%h", i, mem_a, 32'hFFFFFFFE + 32'(i));
         else n_pass++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, 32'h56782211}) $display("FAIL wrap_done got=%b/%h exp=1/56782211", rsp_valid, rsp_rdata);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      $display("misaligned lw @fffffffe -> %h", 32'h56782211);
   endtask

   task automatic test_back_to_back();
      set_req(1'b1, 1'b0, 32'h1, 3'b010, 32'h0);
      #1;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (mem_a !== 32'h1 + 32'(i) || stall !== 1'b1) $display("FAIL b2b_a_split%0d got a=%h exp a=%h", i, mem_a, 32'h1 + 32'(i));
         else n_pass++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b01, 32'hEF123456}) $display("FAIL b2b_a_done got=%b/%h exp=01/ef123456", {stall, rsp_valid}, rsp_rdata);
      else n_pass++;
      @(negedge clk);
      req_addr = 32'h2;
      #1;
      n_checks++;
      if ({stall, rsp_valid, mem_we, mem_ctrl} !== 6'b100010) $display("FAIL b2b_b_first got=%b exp=100010", {stall, rsp_valid, mem_we, mem_ctrl});
      else n_pass++;
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++;
         if (mem_a !== 32'h2 + 32'(i) || stall !== 1'b1) $display("FAIL b2b_b_split%0d got a=%h stall=%b exp a=%h stall=1", i, mem_a, stall, 32'h2 + 32'(i));
         else n_pass++;
         @(negedge clk);
      end
      #1;
      n_checks++;
      if ({stall, rsp_valid, rsp_rdata} !== {2'b01, 32'hBEEF1234}) $display("FAIL b2b_b_done got=%b/%h exp=01/beef1234", {stall, rsp_valid}, rsp_rdata);
      else n_pass++;
      req_valid = 1'b0;
      @(negedge clk);
      $display("back-to-back lw @1 -> %h, lw @2 -> %h", 32'hEF123456, 32'hBEEF1234);
   endtask

   initial begin
      test_reset();
      init_mem();
      test_aligned();
      test_misaligned_word();
      test_misaligned_half(1'b0, 32'hFFFFEF12);
      test_misaligned_half(1'b1, 32'h0000EF12);
      test_store();
      test_reset_mid_split();
      test_wrap();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
